uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver stage that deserialises the asynchronous serial line into bytes.
- Presents each byte on a valid/ready output that feeds the alu byte input (data_i/valid_i/ready_o) directly upstream.
- Provides one output holding register, plus framing-error and overrun status pulses.
- Format is fixed 8N1: one start bit, 8 data bits LSB-first, no parity, one stop bit.

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range 4..65535. Counter width is derived from it.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- rx_i  input  1  asynchronous serial line, idles high
- data_o  output  8  received byte
- valid_o  output  1  data_o holds an unconsumed byte
- ready_i  input  1  downstream (alu) accepts the byte
- busy_o  output  1  receiver is inside a frame (state != IDLE)
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: completed byte dropped because the holding register was full

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: state IDLE; data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - Both synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame; no partial byte, no error pulse.
- Synchroniser: rx_i passes through 2 flops; rx_s is the second flop. All logic below uses rx_s only.
- Timing reference: cycle 0 is the first cycle rx_s is seen 0 while in IDLE. H = CLKS_PER_BIT/2 (integer division); C = CLKS_PER_BIT.
- FSM states:
  - IDLE: wait for rx_s=0, then go to START with the bit counter cleared.
  - START: sample rx_s at cycle H.
    - 1: false start; return to IDLE, no outputs change.
    - 0: go to DATA.
  - DATA: sample bit k (k=0..7) at cycle H+(k+1)*C. Shift in LSB-first. After bit 7, go to STOP.
  - STOP: sample at cycle H+9C.
    - 1: byte complete; return to IDLE.
    - 0: frame_err_o pulses at H+9C+1; byte discarded; go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- busy_o is high in START, DATA, STOP and BREAK.
- Output holding register:
  - On completion, if valid_o=0, or valid_o=1 and ready_i=1 in the completion cycle: load data_o. valid_o=1 from cycle H+9C+1.
  - If valid_o=1 and ready_i=0 at completion: keep the old data_o/valid_o, drop the new byte, pulse overrun_o at H+9C+1.
  - Handshake on valid_o && ready_i. Without a new load, valid_o falls the next cycle.
  - data_o is stable while valid_o=1 and ready_i=0.
  - ready_i has no combinational path to any output.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP, so the minimum frame spacing is 10 bit times.
- Total latency from the rx_i falling edge to valid_o: 2 + H + 9C + 1 cycles.

Test Plan (CLKS_PER_BIT=8, ready_i=1 unless stated):
- Send 0x02, 0x09, 0xAA as 8N1 frames back-to-back. Required: valid_o pulses three times with data_o 2, 9, 170. Each valid_o appears 2+4+72+1=79 cycles after its start edge. No error pulses.
- Hold ready_i=0 and send 0x55 then 0x33. Required:
  - valid_o=1, data_o=0x55 held.
  - overrun_o pulses once at the end of the 0x33 frame.
  - Raising ready_i then yields a single handshake with 0x55.
- Send 0xF0 with stop bit 0, then the line idles high. Required: frame_err_o pulses once; valid_o stays 0; busy_o drops once the line returns high.
- Drive a 2-cycle low glitch on an idle line. Required: returns to IDLE at cycle H; valid_o=0; no error pulses.
- Assert rst_i for 1 cycle during data bit 3 of 0xC3, then send 0x7E cleanly. Required: only 0x7E is delivered; no pulses from the aborted frame.
- Complete a frame exactly in the cycle where ready_i=1 handshakes the previously held byte. Required: no overrun_o; the new byte is loaded and valid_o stays high.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// Byte handshake carrying received UART bytes to the downstream consumer.
interface uart_rx_byte_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a single
// output holding register with framing-error and overrun status pulses.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           rx_i,
    uart_rx_byte_if.master out_if,
    output logic           busy_o,
    output logic           frame_err_o,
    output logic           overrun_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             done;
    logic             load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            rx_s_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            // Counter starts at 0 in the cycle after the edge, hence H-1.
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A byte may replace the held one only if that one is consumed this cycle.
        load    = done && (!valid_q || out_if.ready);
        data_d  = load ? sh_q : data_q;
        valid_d = load ? 1'b1 : (valid_q && !out_if.ready);
        ovr_d   = done && valid_q && !out_if.ready;
    end

    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=8 with hand-computed expectations.
module tb_uart_rx_byte;

    localparam int C = 8;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic clk = 1'b0;
    logic rst_i;
    logic rx_i;
    logic busy_o;
    logic frame_err_o;
    logic overrun_o;

    uart_rx_byte_if bus ();

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .out_if      (bus),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge.
    logic [7:0] hs_q[$];
    int         rise_q[$];
    int         ferr_n = 0;
    int         ovr_n  = 0;
    logic       prev_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (bus.valid && bus.ready) hs_q.push_back(bus.data);
            if (bus.valid && !prev_v) rise_q.push_back(cyc);
            if (frame_err_o) ferr_n++;
            if (overrun_o) ovr_n++;
        end
        prev_v = bus.valid;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hs_at(input int i);
        return (i < hs_q.size()) ? int'(hs_q[i]) : -1;
    endfunction

    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1;
    endfunction

    // One 8N1 frame, cycle by cycle. rst_at aborts the frame (line goes idle),
    // rdy_at drives ready_i high for exactly that one cycle of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at,
                              input int rdy_at, output int t0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0 = cyc;
        for (int t = 0; t < 10 * C; t++) begin
            if (rst_at >= 0 && t >= rst_at) rx_i = 1'b1;
            else                            rx_i = bits[t / C];
            rst_i = (t == rst_at);
            if (rdy_at >= 0) bus.ready = (t == rdy_at);
            @(posedge clk);
            #1;
        end
        rst_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int t0, t1, t2, hb, fb, ob, rb, k;

    initial begin
        rst_i = 1'b1;
        rx_i = 1'b1;
        bus.ready = 1'b1;
        idle(3);
        check("rst_data", int'(bus.data), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ferr", int'(frame_err_o), 0);
        check("rst_ovr", int'(overrun_o), 0);
        rst_i = 1'b0;
        idle(4);

        // Back-to-back frames with ready held high.
        hb = hs_q.size(); rb = rise_q.size(); fb = ferr_n; ob = ovr_n;
        send_frame(8'h02, 1'b1, -1, -1, t0);
        send_frame(8'h09, 1'b1, -1, -1, t1);
        send_frame(8'hAA, 1'b1, -1, -1, t2);
        idle(10);
        check("b2b_count", hs_q.size() - hb, 3);
        check("b2b_d0", hs_at(hb), 2);
        check("b2b_d1", hs_at(hb + 1), 9);
        check("b2b_d2", hs_at(hb + 2), 170);
        check("b2b_lat0", rise_at(rb) - t0, LAT);
        check("b2b_lat1", rise_at(rb + 1) - t1, LAT);
        check("b2b_lat2", rise_at(rb + 2) - t2, LAT);
        check("b2b_ferr", ferr_n - fb, 0);
        check("b2b_ovr", ovr_n - ob, 0);
        check("b2b_valid_low", int'(bus.valid), 0);

        // Overrun while the consumer stalls.
        hb = hs_q.size(); ob = ovr_n;
        bus.ready = 1'b0;
        send_frame(8'h55, 1'b1, -1, -1, t0);
        send_frame(8'h33, 1'b1, -1, -1, t1);
        idle(5);
        check("ovr_valid", int'(bus.valid), 1);
        check("ovr_data", int'(bus.data), 8'h55);
        check("ovr_pulses", ovr_n - ob, 1);
        check("ovr_no_hs", hs_q.size() - hb, 0);
        bus.ready = 1'b1;
        idle(4);
        check("ovr_hs_count", hs_q.size() - hb, 1);
        check("ovr_hs_data", hs_at(hb), 8'h55);
        check("ovr_valid_drop", int'(bus.valid), 0);

        // Framing error followed by a held-low line.
        hb = hs_q.size(); fb = ferr_n;
        send_frame(8'hF0, 1'b0, -1, -1, t0);
        idle(16);
        check("ferr_busy_break", int'(busy_o), 1);
        check("ferr_valid", int'(bus.valid), 0);
        rx_i = 1'b1;
        idle(5);
        check("ferr_busy_drop", int'(busy_o), 0);
        check("ferr_pulses", ferr_n - fb, 1);
        check("ferr_no_hs", hs_q.size() - hb, 0);

        // Two-cycle glitch is rejected at the start-bit midpoint.
        hb = hs_q.size(); fb = ferr_n; ob = ovr_n;
        k = cyc;
        rx_i = 1'b0;
        idle(2);
        rx_i = 1'b1;
        idle(4);
        check("glitch_busy_h", int'(busy_o), 1);
        check("glitch_cyc", cyc - k, 6);
        idle(1);
        check("glitch_idle", int'(busy_o), 0);
        idle(20);
        check("glitch_valid", int'(bus.valid), 0);
        check("glitch_hs", hs_q.size() - hb, 0);
        check("glitch_ferr", ferr_n - fb, 0);
        check("glitch_ovr", ovr_n - ob, 0);

        // Reset during data bit 3 of 0xC3, then a clean 0x7E.
        hb = hs_q.size(); fb = ferr_n; ob = ovr_n;
        send_frame(8'hC3, 1'b1, 4 * C + 3, -1, t0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_valid", int'(bus.valid), 0);
        send_frame(8'h7E, 1'b1, -1, -1, t1);
        idle(5);
        check("abort_hs_count", hs_q.size() - hb, 1);
        check("abort_hs_data", hs_at(hb), 8'h7E);
        check("abort_ferr", ferr_n - fb, 0);
        check("abort_ovr", ovr_n - ob, 0);

        // Completion coincides with the handshake of the held byte.
        hb = hs_q.size(); ob = ovr_n;
        bus.ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1, -1, t0);
        send_frame(8'hA5, 1'b1, -1, LAT - 1, t1);
        check("coinc_valid", int'(bus.valid), 1);
        check("coinc_data", int'(bus.data), 8'hA5);
        check("coinc_hs_count", hs_q.size() - hb, 1);
        check("coinc_hs_data", hs_at(hb), 8'h3C);
        check("coinc_ovr", ovr_n - ob, 0);
        bus.ready = 1'b1;
        idle(4);
        check("coinc_drain_count", hs_q.size() - hb, 2);
        check("coinc_drain_data", hs_at(hb + 1), 8'hA5);
        check("coinc_valid_drop", int'(bus.valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
